// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and constants for the instruction-cache refill controller.
// Holds the FSM state enum, AXI encodings and the beats-per-block helper.
package cache_refill_pkg;

  localparam int ADDR_WIDTH     = 64;
  localparam int BLOCK_WIDTH    = 512;
  localparam int AXI_DATA_WIDTH = 64;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    FILL,
    GUARD
  } refill_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int beats_of(int bw, int dw);
    return bw / dw;
  endfunction

  localparam int BEATS = beats_of(BLOCK_WIDTH, AXI_DATA_WIDTH);

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// AXI4 read-channel bundle (AR + R) between refill master and memory.
// Ports: master drives ar*/rready, slave drives arready and r* returns.
interface icache_refill_ctrl_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;

  modport master (
    output arvalid, araddr, arlen,
    output arsize, arburst, rready,
    input  arready, rvalid, rdata,
    input  rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen,
    input  arsize, arburst, rready,
    output arready, rvalid, rdata,
    output rresp, rlast
  );
endinterface

// File: rtl/icache_refill_ctrl_buffer.sv
// Beat counter plus block assembly register for one refill burst.
// Ports: clk/rst, clr restarts, wr stores wdata at slice cnt; block, last out.
module refill_buffer #(
  parameter int BLOCK_WIDTH = 512,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  output logic [BLOCK_WIDTH-1:0] block,
  output logic                   last
);
  localparam int BEATS = BLOCK_WIDTH / DATA_WIDTH;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt   <= '0;
      block <= '0;
    end else if (wr) begin
      for (int k = 0; k < BEATS; k++) begin
        if (cnt == CW'(k))
          block[k*DATA_WIDTH +: DATA_WIDTH] <= wdata;
      end
      cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(BEATS - 1));
endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache refill master: one AXI4 INCR burst per fetch miss, then block write.
// Ports: clk/arst, fetch hit/addr in, stall/we/block/bus_error out, axi master.
module icache_refill_ctrl
  import cache_refill_pkg::*;
#(
  parameter int ADDR_WIDTH     = cache_refill_pkg::ADDR_WIDTH,
  parameter int BLOCK_WIDTH    = cache_refill_pkg::BLOCK_WIDTH,
  parameter int AXI_DATA_WIDTH = cache_refill_pkg::AXI_DATA_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_icache_hit,
  input  logic [ADDR_WIDTH-1:0]  i_read_addr,
  output logic                   o_stall_fetch,
  output logic                   o_instr_we,
  output logic [BLOCK_WIDTH-1:0] o_instr_block,
  output logic                   o_bus_error,
  icache_refill_ctrl_if.master   axi
);
  localparam int NBEATS = beats_of(BLOCK_WIDTH, AXI_DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK =
    ADDR_WIDTH'(BLOCK_WIDTH / 8 - 1);

  refill_state_t         state;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  err;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  we_q;
  logic                  berr_q;
  logic                  miss;
  logic                  beat;
  logic                  last_beat;
  logic                  err_nxt;

  assign miss = (state == IDLE) && !i_icache_hit;
  assign beat = (state == DATA) && axi.rvalid;

  // A beat errors on a bad response or when rlast and the
  // count disagree (early or missing last).
  assign err_nxt = err
                 | (axi.rresp != AXI_RESP_OKAY)
                 | (axi.rlast != last_beat);

  refill_buffer #(
    .BLOCK_WIDTH (BLOCK_WIDTH),
    .DATA_WIDTH  (AXI_DATA_WIDTH)
  ) u_buf (
    .clk   (i_clk),
    .rst   (i_arst),
    .clr   (miss),
    .wr    (beat),
    .wdata (axi.rdata),
    .block (o_instr_block),
    .last  (last_beat)
  );

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state     <= IDLE;
      addr      <= '0;
      err       <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      we_q      <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      berr_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!i_icache_hit) begin
            addr      <= i_read_addr & ~OFS_MASK;
            err       <= 1'b0;
            arvalid_q <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (axi.rvalid) begin
            err <= err_nxt;
            if (last_beat || axi.rlast) begin
              rready_q <= 1'b0;
              we_q     <= 1'b1;
              berr_q   <= err_nxt;
              state    <= FILL;
            end
          end
        end
        FILL:    state <= GUARD;
        GUARD:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_stall_fetch = (state != IDLE) || !i_icache_hit;
  assign o_instr_we    = we_q;
  assign o_bus_error   = berr_q;

  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = addr;
  assign axi.arlen   = 8'(NBEATS - 1);
  assign axi.arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.rready  = rready_q;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl with a directed AXI slave.
// Stimulus queues expected AR addresses and fills; a monitor checks them.
module tb_icache_refill_ctrl;
  import cache_refill_pkg::*;

  localparam int AW = 64;
  localparam int BW = 512;
  localparam int DW = 64;
  localparam int NB = BW / DW;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          hit = 1'b1;
  logic [AW-1:0] raddr = '0;
  logic          stall;
  logic          we;
  logic          berr;
  logic [BW-1:0] blk;

  icache_refill_ctrl_if #(.AW(AW), .DW(DW)) axi ();

  icache_refill_ctrl dut (
    .i_clk         (clk),
    .i_arst        (arst),
    .i_icache_hit  (hit),
    .i_read_addr   (raddr),
    .o_stall_fetch (stall),
    .o_instr_we    (we),
    .o_instr_block (blk),
    .o_bus_error   (berr),
    .axi           (axi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BW-1:0] blk;
    logic          err;
    int            lat;
  } fill_t;

  fill_t         fq[$];
  logic [AW-1:0] aq[$];
  fill_t         em;
  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  int miss_cyc = 0;

  task automatic chk(input string nm,
                     input logic [BW-1:0] act,
                     input logic [BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  always @(negedge clk) begin
    if (!arst) begin
      if (axi.arvalid && axi.arready) begin
        if (aq.size() == 0) bad("ar_unexpected");
        else chk("araddr", BW'(axi.araddr), BW'(aq.pop_front()));
      end
      if (we) begin
        we_cnt++;
        if (fq.size() == 0) bad("we_unexpected");
        else begin
          em = fq.pop_front();
          chk("block", blk, em.blk);
          chk("bus_error", BW'(berr), BW'(em.err));
          if (em.lat >= 0)
            chk("latency", BW'(cyc - miss_cyc), BW'(em.lat));
        end
      end else if (berr) bad("berr_without_we");
    end
  end

  function automatic logic sel(input int w);
    case (w)
      0:       return axi.arvalid;
      1:       return axi.rready;
      default: return we;
    endcase
  endfunction

  task automatic wait_for(input int w);
    int n = 0;
    while (!sel(w) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!sel(w)) bad($sformatf("timeout_%0d", w));
  endtask

  task automatic miss(input logic [AW-1:0] a, input int dly);
    logic [AW-1:0] exp_a;
    logic stable;
    @(posedge clk); #1;
    exp_a = {a[AW-1:6], 6'b0};
    hit = 1'b0;
    raddr = a;
    miss_cyc = cyc;
    aq.push_back(exp_a);
    axi.arready = (dly == 0);
    wait_for(0);
    stable = 1'b1;
    for (int i = 0; i < dly; i++) begin
      if (axi.araddr !== exp_a || !axi.arvalid) stable = 1'b0;
      raddr = a + 64'h100;
      @(posedge clk); #1;
    end
    if (dly > 0) chk("ar_stable", BW'(stable), BW'(1));
    axi.arready = 1'b1;
    wait_for(1);
    axi.arready = 1'b0;
  endtask

  task automatic burst(input logic [DW-1:0] base,
                       input int gap, input int err_k,
                       input int last_k, input int stop_k,
                       input int lat);
    fill_t e;
    logic ok;
    e.blk = '0;
    e.err = (last_k < 0);
    e.lat = lat;
    ok = 1'b1;
    for (int k = 0; k < NB; k++) begin
      if (k >= stop_k) break;
      if (gap != 0 && k % 2 == 1) begin
        axi.rvalid = 1'b0;
        @(posedge clk); #1;
        ok &= stall;
      end
      axi.rvalid = 1'b1;
      axi.rdata = base + DW'(k);
      axi.rresp = (k == err_k) ? 2'b10 : 2'b00;
      axi.rlast = (k == last_k);
      e.blk[k*DW +: DW] = base + DW'(k);
      if (k == err_k) e.err = 1'b1;
      if (k == last_k && k != NB - 1) e.err = 1'b1;
      if (stop_k >= NB && (k == last_k || k == NB - 1))
        fq.push_back(e);
      @(posedge clk); #1;
      ok &= stall;
      if (k == last_k) break;
    end
    axi.rvalid = 1'b0;
    axi.rlast = 1'b0;
    axi.rresp = 2'b00;
    chk("stall_in_refill", BW'(ok), BW'(1));
  endtask

  task automatic tail(input int exp_we);
    wait_for(2);
    @(posedge clk); #1;
    chk("we_one_cycle", BW'(we), BW'(0));
    chk("guard_no_ar", BW'(axi.arvalid), BW'(0));
    chk("guard_stall", BW'(stall), BW'(1));
    @(posedge clk); #1;
    chk("idle_no_ar", BW'(axi.arvalid), BW'(0));
    chk("idle_miss_stall", BW'(stall), BW'(1));
    hit = 1'b1;
    #1;
    chk("hit_stall_drop", BW'(stall), BW'(0));
    @(posedge clk); #1;
    chk("idle_quiet", BW'(axi.arvalid), BW'(0));
    chk("we_count", BW'(we_cnt), BW'(exp_we));
  endtask

  initial begin
    axi.arready = 1'b0;
    axi.rvalid = 1'b0;
    axi.rdata = '0;
    axi.rresp = 2'b00;
    axi.rlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    arst = 1'b0;
    chk("rst_arvalid", BW'(axi.arvalid), BW'(0));
    chk("rst_rready", BW'(axi.rready), BW'(0));
    chk("rst_we", BW'(we), BW'(0));
    chk("rst_block", blk, '0);
    chk("rst_stall", BW'(stall), BW'(0));
    chk("arlen", BW'(axi.arlen), BW'(7));
    chk("arsize", BW'(axi.arsize), BW'(3));
    chk("arburst", BW'(axi.arburst), BW'(1));

    miss(64'h1044, 0);
    burst(64'h0, 0, -1, NB - 1, NB, 10);
    tail(1);

    miss(64'h2080, 5);
    burst(64'hA5A5_0000_0000_0010, 1, -1, NB - 1, NB, 19);
    tail(2);

    miss(64'h30C0, 0);
    burst(64'h3300_0000_0000_0000, 0, 3, NB - 1, NB, -1);
    tail(3);

    miss(64'h3100, 0);
    burst(64'h4400_0000_0000_0000, 0, -1, NB - 1, NB, -1);
    tail(4);

    miss(64'h5000, 0);
    burst(64'h5500_0000_0000_0000, 0, -1, 5, NB, -1);
    tail(5);

    miss(64'h6000, 0);
    burst(64'h6600_0000_0000_0000, 0, -1, -1, NB, -1);
    tail(6);

    miss(64'h7040, 0);
    burst(64'h7700_0000_0000_0000, 0, -1, NB - 1, 5, -1);
    arst = 1'b1;
    hit = 1'b1;
    @(posedge clk); #1;
    chk("abort_arvalid", BW'(axi.arvalid), BW'(0));
    chk("abort_rready", BW'(axi.rready), BW'(0));
    chk("abort_we", BW'(we), BW'(0));
    chk("abort_berr", BW'(berr), BW'(0));
    chk("abort_block", blk, '0);
    chk("abort_stall", BW'(stall), BW'(0));
    arst = 1'b0;
    miss(64'h8000, 0);
    burst(64'h8800_0000_0000_0000, 0, -1, NB - 1, NB, 10);
    tail(7);

    chk("ar_queue_empty", BW'(aq.size()), BW'(0));
    chk("fill_queue_empty", BW'(fq.size()), BW'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
